// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch port and program-loader stream of the instruction memory.
// The master side is the fetch stage / boot loader; the slave side is the memory.
interface imem_fetch_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) ();
  // fetch port
  logic [31:0]     pc;
  logic            req;
  logic            ready;
  logic            valid;
  logic [XLEN-1:0] instr;
  logic            fault;
  // loader stream
  logic            ld_start;
  logic [AW-1:0]   ld_base;
  logic            ld_valid;
  logic            ld_last;
  logic [XLEN-1:0] ld_data;
  logic            ld_busy;
  logic [AW:0]     ld_count;

  modport master (
    output pc, req, ld_start, ld_base, ld_valid, ld_last, ld_data,
    input  ready, valid, instr, fault, ld_busy, ld_count
  );

  modport slave (
    input  pc, req, ld_start, ld_base, ld_valid, ld_last, ld_data,
    output ready, valid, instr, fault, ld_busy, ld_count
  );
endinterface

// File: rtl/imem_fetch.sv
// imem_fetch: DEPTH x XLEN instruction memory with a streaming program loader
// and a registered (1-cycle) request/valid fetch port. Misaligned or
// out-of-range PCs return NOP with fault set instead of aliasing.
module imem_fetch #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 32,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
  input logic         clk,
  input logic         rst,
  imem_fetch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_e;

  state_e          state_r;
  state_e          state_nxt_s;
  logic [AW-1:0]   ptr_r;
  logic [AW:0]     count_r;
  // Words are stored XOR NOP so an all-zero power-up image reads back as NOP;
  // the array is never touched by rst, so loaded programs survive a reset.
  logic [XLEN-1:0] mem_r [DEPTH];
  logic            valid_r;
  logic            fault_r;
  logic [XLEN-1:0] instr_r;
  logic            busy_s;
  logic            ready_s;
  logic            accept_s;
  logic            we_s;
  logic            bad_pc_s;

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Loader next state: start a session from IDLE, leave LOAD on the last word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.ld_start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (bus.ld_valid && bus.ld_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Loader outputs: busy flag, write strobe, and fetch interlock.
  always_comb begin
    busy_s   = (state_r == LOAD);
    we_s     = busy_s && bus.ld_valid;
    ready_s  = !busy_s && !bus.ld_start;
    accept_s = bus.req && ready_s;
  end

  // Fetch address check: misaligned or word index beyond DEPTH.
  always_comb begin
    bad_pc_s = (bus.pc[1:0] != 2'b00) || ({2'b00, bus.pc[31:2]} >= 32'(DEPTH));
  end

  // Write pointer and word counter; the counter holds after the session ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= '0;
      count_r <= '0;
    end else if (state_r == IDLE) begin
      if (bus.ld_start) begin
        ptr_r   <= bus.ld_base;
        count_r <= '0;
      end
    end else if (bus.ld_valid) begin
      ptr_r <= ptr_r + AW'(1);
      if (count_r != (AW+1)'(DEPTH)) begin
        count_r <= count_r + (AW+1)'(1);
      end
    end
  end

  // Memory write port; a reset edge abandons the session without writing.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_r[ptr_r] <= bus.ld_data ^ NOP;
    end
  end

  // Registered fetch result; instr holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      fault_r <= 1'b0;
      instr_r <= NOP;
    end else begin
      valid_r <= accept_s;
      fault_r <= accept_s && bad_pc_s;
      if (accept_s) begin
        instr_r <= bad_pc_s ? NOP : (mem_r[bus.pc[AW+1:2]] ^ NOP);
      end
    end
  end

  assign bus.ready    = ready_s;
  assign bus.valid    = valid_r;
  assign bus.fault    = fault_r;
  assign bus.instr    = instr_r;
  assign bus.ld_busy  = busy_s;
  assign bus.ld_count = count_r;
endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a streaming program loader and a request/valid fetch port. It replaces the fixed 32×32 combinational instruction ROM. The block sits between the PC/fetch stage of the RISC-V core and the testbench or boot loader that fills program memory. Reads are registered (1-cycle latency), and misaligned or out-of-range PCs are flagged rather than silently aliased.

## Interface
Parameters:
- XLEN, 32, instruction/data word width in bits.
- DEPTH, 32, number of words; power of two, ≥ 2.
- AW, $clog2(DEPTH), word-index width (derived, not overridden).
- NOP, 32'h00000013, word returned on faults and memory power-up value.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  byte address of requested instruction.
- req  in  1  fetch request; accepted when req && ready.
- ready  out  1  block can accept a fetch this cycle.
- valid  out  1  instr/fault hold a result this cycle (1-cycle pulse).
- instr  out  XLEN  fetched instruction.
- fault  out  1  result is for a misaligned or out-of-range pc.
- ld_start  in  1  begin load session at word index ld_base.
- ld_base  in  AW  first word index of the load session.
- ld_valid  in  1  ld_data is a word to write.
- ld_last  in  1  qualifies ld_valid: final word of the session.
- ld_data  in  XLEN  word to write.
- ld_busy  out  1  load session active.
- ld_count  out  AW+1  words written in current/last session.

## Operation
- Storage: DEPTH×XLEN array, every word NOP at time zero. Contents are not cleared by rst.
- Loader FSM, states IDLE and LOAD:
  - IDLE: ld_start → LOAD, ptr←ld_base, ld_count←0. ld_valid in IDLE is ignored.
  - LOAD: on ld_valid, mem[ptr]←ld_data, ptr←(ptr+1) mod DEPTH (wraps DEPTH-1→0), ld_count←ld_count+1 (saturates at DEPTH). ld_valid&&ld_last writes, then → IDLE.
  - ld_start while in LOAD is ignored.
  - ld_busy = (state==LOAD).
- Fetch:
  - ready = !ld_busy && !ld_start. No fetch is accepted while loading or in the cycle a session starts.
  - Accepted fetch at cycle N: at N+1 valid=1.
  - If pc[1:0]≠0 or pc[31:2] ≥ DEPTH: fault=1, instr=NOP.
  - Otherwise fault=0, instr=mem[pc[AW+1:2]].
  - When no fetch was accepted in the previous cycle: valid=0 and fault=0. instr holds its last value.
  - Fetches are back-to-back capable: one per cycle, fully pipelined.

## Timing
- Reset values: valid=0, fault=0, instr=NOP, ld_busy=0, ld_count=0, state=IDLE, ptr=0.
- Reset mid-load: session is abandoned next edge; words already written remain.
- Reset with a fetch outstanding: the result is dropped (valid=0 after reset edge).
- Fetch latency is exactly 1 cycle. There is no backpressure, so the consumer must take valid when it is asserted.
- Read/write ordering: a fetch issued the cycle after the ld_last write sees the new data (write-first across cycles). Same-cycle read/write cannot occur because ready=0.
- ld_count is updated on the same edge as the write and is readable the next cycle. It is held after returning to IDLE until the next ld_start.

## Test plan
- Reset then idle: assert rst for 2 cycles. Expect valid=0, fault=0, instr=32'h00000013, ld_busy=0, ld_count=0, ready=1.
- Load and fetch: ld_start, ld_base=0; write 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003 (last on third). Then req with pc=0,4,8 back-to-back. Expect valid on 3 consecutive cycles with those words, fault=0, ld_count=3.
- Wrap-around load: ld_base=DEPTH-1; write 32'h11111111, 32'h22222222(last). Fetch pc=4*(DEPTH-1) → 32'h11111111. Fetch pc=0 → 32'h22222222.
- Faults: pc=32'h00000002 → valid=1, fault=1, instr=NOP. pc=4*DEPTH → fault=1, instr=NOP. Following aligned pc=4 → fault=0.
- Interlock: assert req during LOAD → ready=0, no valid. Assert ld_start with req in the same cycle → fetch not accepted. ld_start during LOAD → ignored, ld_count keeps counting.
- Reset mid-load: write 2 of 4 words, assert rst. Expect ld_busy=0 next cycle. Fetch shows the 2 written words; unwritten words keep their prior values.
